// File: rtl/instr_mem_pkg.sv
`default_nettype none
// =============================================================================
// instr_mem_pkg : shared constants and FSM state type for instr_mem_responder
// Rev 1.0
// =============================================================================
package instr_mem_pkg;

  localparam logic [2:0] SEG_OP     = 3'b101;
  localparam logic [2:0] JMP_OP     = 3'b111;
  localparam int         INSTR_W    = 128;
  localparam int         ADDR_W     = 33;
  localparam int         WORD_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_ram_sp.sv
`default_nettype none
// =============================================================================
// instr_ram_sp : synchronous RAM, one write port and one read-first read port
// Rev 1.0
// =============================================================================
module instr_ram_sp #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Non-blocking update gives read-first behaviour on a same-index collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// =============================================================================
// instr_mem_responder : CPU instruction-read responder over a host-loaded RAM.
// Optional INSTR_MEM_PARITY_EN adds stored even parity and a parity_err pulse.
// Rev 1.0
// =============================================================================
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int AW         = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_read_valid,
  input  logic [ADDR_W-1:0]  cpu_read_addr,
  output logic [INSTR_W-1:0] cpu_read_data,
  output logic               cpu_read_ack,
  input  logic               host_wr_en,
  input  logic [AW-1:0]      host_wr_addr,
  input  logic [INSTR_W-1:0] host_wr_data,
  output logic               busy,
  output logic               addr_err,
`ifdef INSTR_MEM_PARITY_EN
  output logic               parity_err,
`endif
  input  logic               err_clr
);

  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LATENCY - 1);
`ifdef INSTR_MEM_PARITY_EN
  localparam int RAM_W = INSTR_W + 1;
`else
  localparam int RAM_W = INSTR_W;
`endif

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic               done;
  logic [CNT_W-1:0]   lat_cnt;
  logic               range_err;
  logic               align_err;
  logic               range_err_q;
  logic [AW-1:0]      rd_idx;
  logic [RAM_W-1:0]   ram_wdata;
  logic [RAM_W-1:0]   ram_q;

  assign rd_idx    = cpu_read_addr[AW+OFF_W-1:OFF_W];
  assign range_err = |cpu_read_addr[ADDR_W-1:AW+OFF_W];
  assign align_err = |cpu_read_addr[OFF_W-1:0];
  assign busy      = (state != IDLE);

`ifdef INSTR_MEM_PARITY_EN
  assign ram_wdata = {^host_wr_data, host_wr_data};
`else
  assign ram_wdata = host_wr_data;
`endif

  instr_ram_sp #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (RAM_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (host_wr_en),
    .wr_addr (host_wr_addr),
    .wr_data (ram_wdata),
    .rd_en   (accept),
    .rd_addr (rd_idx),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_read_valid) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          done       = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!cpu_read_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt       <= '0;
      range_err_q   <= 1'b0;
      cpu_read_ack  <= 1'b0;
      cpu_read_data <= '0;
      addr_err      <= 1'b0;
    end else begin
      cpu_read_ack <= done;
      if (accept) begin
        lat_cnt     <= LAT_LOAD;
        range_err_q <= range_err;
      end else if (state == WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      // Out-of-range reads return opcode 0 so the fetch engine idles.
      if (done) cpu_read_data <= range_err_q ? '0 : ram_q[INSTR_W-1:0];
      if (err_clr)                             addr_err <= 1'b0;
      else if (accept && (range_err || align_err)) addr_err <= 1'b1;
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err <= 1'b0;
    else      parity_err <= done && !range_err_q && (^ram_q);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`default_nettype none
// =============================================================================
// tb_instr_mem_responder : directed self-checking bench for instr_mem_responder
// Rev 1.0
// =============================================================================
module tb_instr_mem_responder;
  import instr_mem_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_read_valid;
  logic [32:0]  cpu_read_addr;
  logic [127:0] cpu_read_data;
  logic         cpu_read_ack;
  logic         host_wr_en;
  logic [9:0]   host_wr_addr;
  logic [127:0] host_wr_data;
  logic         busy;
  logic         addr_err;
  logic         err_clr;
`ifdef INSTR_MEM_PARITY_EN
  logic         parity_err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic par_at_ack;

  localparam logic [127:0] D0 = 128'hA000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] D1 = 128'hE000_0000_0000_0000_0000_0000_0000_0005;
  localparam logic [127:0] DY = 128'hA000_0000_0000_0000_0000_0000_1111_2222;
  localparam logic [127:0] DX = 128'hE000_0000_0000_0000_0000_0000_3333_4444;
  localparam logic [127:0] D3 = 128'hA000_0000_0000_0000_0000_0000_0000_0007;

  instr_mem_responder u_dut (
    .clk            (clk),
    .rst            (rst_n),
    .cpu_read_valid (cpu_read_valid),
    .cpu_read_addr  (cpu_read_addr),
    .cpu_read_data  (cpu_read_data),
    .cpu_read_ack   (cpu_read_ack),
    .host_wr_en     (host_wr_en),
    .host_wr_addr   (host_wr_addr),
    .host_wr_data   (host_wr_data),
    .busy           (busy),
    .addr_err       (addr_err),
`ifdef INSTR_MEM_PARITY_EN
    .parity_err     (parity_err),
`endif
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [9:0] idx, input logic [127:0] data);
    host_wr_en   = 1'b1;
    host_wr_addr = idx;
    host_wr_data = data;
    tick();
    host_wr_en   = 1'b0;
  endtask

  // Raises valid, waits for ack (bounded), holds valid one cycle past ack,
  // then drops it and checks that busy releases.
  task automatic do_read(input logic [32:0] addr, input logic [127:0] exp_data,
                         input logic exp_err, input string tag);
    int  cyc;
    bit  got;
    cpu_read_valid = 1'b1;
    cpu_read_addr  = addr;
    cyc = 0;
    got = 0;
    while (!got && cyc < 20) begin
      tick();
      cyc++;
      host_wr_en = 1'b0;
      if (cpu_read_ack) got = 1;
    end
`ifdef INSTR_MEM_PARITY_EN
    par_at_ack = parity_err;
`else
    par_at_ack = 1'b0;
`endif
    // accept edge plus two latency edges
    check({tag, "_latency"}, 128'(cyc), 128'd3);
    check({tag, "_data"}, cpu_read_data, exp_data);
    check({tag, "_addr_err"}, 128'(addr_err), 128'(exp_err));
    tick();
    check({tag, "_no_reack"}, 128'(cpu_read_ack), 128'd0);
    check({tag, "_busy_hold"}, 128'(busy), 128'd1);
    cpu_read_valid = 1'b0;
    tick();
    check({tag, "_busy_release"}, 128'(busy), 128'd0);
  endtask

  initial begin
    bit seen_ack;
    rst_n          = 1'b0;
    cpu_read_valid = 1'b0;
    cpu_read_addr  = '0;
    host_wr_en     = 1'b0;
    host_wr_addr   = '0;
    host_wr_data   = '0;
    err_clr        = 1'b0;
    par_at_ack     = 1'b0;
    repeat (3) tick();
    check("rst_ack",      128'(cpu_read_ack), 128'd0);
    check("rst_data",     cpu_read_data,      128'd0);
    check("rst_busy",     128'(busy),         128'd0);
    check("rst_addr_err", 128'(addr_err),     128'd0);
    rst_n = 1'b1;
    tick();

    host_write(10'd0, D0);
    host_write(10'd1, D1);
    host_write(10'd2, DY);

    do_read(33'h0,  D0, 1'b0, "rd0");
    check("rd0_opcode", 128'(cpu_read_data[127:125]), 128'(SEG_OP));
    do_read(33'h10, D1, 1'b0, "rd1");
    check("rd1_opcode", 128'(cpu_read_data[127:125]), 128'(JMP_OP));

    do_read(33'h1_0000_0000, 128'd0, 1'b1, "rd_range");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr_range", 128'(addr_err), 128'd0);

    do_read(33'h14, D1, 1'b1, "rd_misalign");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr_misalign", 128'(addr_err), 128'd0);

    // write and read-accept of the same index in the same cycle
    host_wr_en   = 1'b1;
    host_wr_addr = 10'd2;
    host_wr_data = DX;
    do_read(33'h20, DY, 1'b0, "rd_collide");
    do_read(33'h20, DX, 1'b0, "rd_after_wr");

    // reset during WAIT aborts the read
    cpu_read_valid = 1'b1;
    cpu_read_addr  = 33'h0;
    tick();
    check("abort_busy_before", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy_now", 128'(busy), 128'd0);
    cpu_read_valid = 1'b0;
    seen_ack = 0;
    repeat (4) begin
      tick();
      if (cpu_read_ack) seen_ack = 1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      if (cpu_read_ack) seen_ack = 1;
    end
    check("abort_no_ack", 128'(seen_ack), 128'd0);
    do_read(33'h0, D0, 1'b0, "rd_post_rst");

`ifdef INSTR_MEM_PARITY_EN
    check("par_clean", 128'(par_at_ack), 128'd0);
    host_write(10'd3, D3);
    u_dut.u_ram.mem[3][128] = ~u_dut.u_ram.mem[3][128];
    do_read(33'h30, D3, 1'b0, "rd_par");
    check("par_flag", 128'(par_at_ack), 128'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Responder end of the CPU instruction-read handshake: accepts cpu_read_valid/cpu_read_addr, returns one 128-bit instruction word with a single-cycle cpu_read_ack.
- Holds the waveform-generation program (segment opcode 3'b101, jump opcode 3'b111 in bits [127:125]) in an internal RAM.
- The RAM is loaded by a host write port.
- Sits between the host register/DMA loader and the instruction fetch engine.

Parameters:
- DEPTH, 1024, number of 128-bit instruction words (power of two).
- AW, 10, word-index width, log2(DEPTH).
- RD_LATENCY, 2, cycles from request accept to ack; legal range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_read_valid  in  1  read request; level, held by requester until ack, may stay high 1 cycle after ack
- cpu_read_addr  in  33  byte address; 16-byte stride, word index = addr[AW+3:4]
- cpu_read_data  out  128  instruction word, valid only in the ack cycle
- cpu_read_ack  out  1  single-cycle completion pulse
- host_wr_en  in  1  host write strobe
- host_wr_addr  in  AW  host write word index
- host_wr_data  in  128  host write data
- busy  out  1  high from request accept until release
- addr_err  out  1  sticky flag: out-of-range or misaligned read seen
- err_clr  in  1  clears addr_err

Behaviour:
- Reset (rst low, async): state IDLE; cpu_read_ack=0, cpu_read_data=0, busy=0, addr_err=0, latency counter=0. RAM contents are not reset. Reset mid-read aborts the read with no ack.
- FSM IDLE: on cpu_read_valid=1, latch the address and sample RAM[index] (read-first), load the counter with RD_LATENCY-1, then go to WAIT.
- FSM WAIT: decrement the counter each cycle. When the counter is 0, register data, pulse cpu_read_ack for 1 cycle and go to RELEASE.
  - With RD_LATENCY=1, ack is asserted the cycle after accept.
  - Ack always comes exactly RD_LATENCY cycles after the accept edge.
- FSM RELEASE: wait for cpu_read_valid=0, then go to IDLE. A valid still high after ack is never re-acked. A new request is accepted at the earliest in the cycle after valid is seen low.
- cpu_read_data holds its last value outside the ack cycle and is meaningful only while ack=1.
- busy=1 in WAIT and RELEASE.
- Range check: if addr[32:AW+4] != 0, the returned data is 128'd0 (opcode 3'b000, so the requester goes idle) and addr_err is set.
- Alignment check: if addr[3:0] != 0, the low bits are ignored for the read and addr_err is set.
- Host writes are accepted every cycle regardless of state.
- A write and a read accept to the same index in the same cycle return the old data (read-first). A write during WAIT to the latched index does not alter the pending data.
- err_clr has priority over a simultaneous new error set, i.e. the flag is clear the next cycle.
- cpu_read_valid dropping during WAIT: the read completes and ack is still pulsed; the FSM then passes through RELEASE to IDLE.

Optional Feature:
- INSTR_MEM_PARITY_EN defined:
  - RAM stores 129 bits: even parity of host_wr_data is computed on write.
  - On read the parity is re-checked. Output port parity_err (1 bit) pulses together with cpu_read_ack on mismatch.
  - Out-of-range reads never flag parity.
- Macro undefined: no parity storage; parity_err is absent.

Decomposition:
- Shared package instr_mem_pkg holds:
  - opcode constants SEG_OP=3'b101 and JMP_OP=3'b111;
  - INSTR_W=128 and ADDR_W=33;
  - WORD_BYTES=16;
  - the FSM state enum {IDLE, WAIT, RELEASE}.
- One sub-module: instr_ram_sp, a single-port-read/single-port-write synchronous RAM (read-first, optional parity bit). The FSM, latency counter and error logic stay in the top.

Test Plan:
- Host writes RAM[0]=128'hA000...0001 and RAM[1]=128'hE000...0005. Read addr 0x0 (RD_LATENCY=2) -> ack exactly 2 cycles after accept, data=A000...0001, single ack pulse.
- Requester holds valid high 1 cycle after ack -> no second ack. Next request to addr 0x10 -> ack with E000...0005.
- Read addr 33'h1_0000_0000 -> data=0, addr_err=1. Assert err_clr -> addr_err=0 the next cycle.
- Read addr 0x14 -> data=RAM[1], addr_err=1.
- Same-cycle host write RAM[2]=X and read accept of 0x20, RAM[2] previously Y -> returns Y. A following read returns X.
- Assert rst low during WAIT -> ack never pulses, busy=0 immediately. After release, read 0x0 -> normal ack, RAM contents preserved.
- With INSTR_MEM_PARITY_EN, force a parity bit flip in RAM[3], then read 0x30 -> parity_err=1 in the ack cycle.
